// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package serial_cmp_pkg;

  // Number of operand bits examined per clock.
  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StDone
  } state_e;

  // One-hot comparison result.
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit magnitude comparator with one-hot G/E/L result.
module cmp2_slice
  import serial_cmp_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output cmp_res_t           res
);

  // Exactly one flag is set for any input pair.
  always_comb begin
    res    = '0;
    res.gt = (a > b);
    res.eq = (a == b);
    res.lt = (a < b);
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Handshaked MSB-first serial magnitude comparator, one 2-bit digit per clock.
// Define SERIAL_CMP_SIGNED_EN for two's-complement operands; the default build is unsigned.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      a,
  input  logic [WIDTH-1:0]                      b,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  gt,
  output logic                                  eq,
  output logic                                  lt,
  output logic [$clog2(WIDTH/DIGIT_W+1)-1:0]    ncmp
);

  localparam int unsigned DIGITS = WIDTH / DIGIT_W;
  localparam int unsigned CntW   = $clog2(DIGITS + 1);

  state_e               state_q;
  logic [WIDTH-1:0]     sa_q, sb_q;
  logic [CntW-1:0]      idx_q, cnt_q;
  logic [DIGIT_W-1:0]   dig_a, dig_b;
  cmp_res_t             res;

`ifdef SERIAL_CMP_SIGNED_EN
  logic first_digit;

  // Flipping both sign bits on the leading digit maps two's complement onto unsigned order.
  assign first_digit = (idx_q == CntW'(DIGITS - 1));
  assign dig_a = {sa_q[WIDTH-1] ^ first_digit, sa_q[WIDTH-2]};
  assign dig_b = {sb_q[WIDTH-1] ^ first_digit, sb_q[WIDTH-2]};
`else
  assign dig_a = sa_q[WIDTH-1 -: DIGIT_W];
  assign dig_b = sb_q[WIDTH-1 -: DIGIT_W];
`endif

  cmp2_slice u_slice (
    .a   (dig_a),
    .b   (dig_b),
    .res (res)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sa_q      <= '0;
      sb_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      ncmp      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // in_ready rises one cycle after reset release or result transfer.
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sa_q     <= a;
            sb_q     <= b;
            idx_q    <= CntW'(DIGITS - 1);
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StCmp;
          end
        end
        StCmp: begin
          cnt_q <= cnt_q + CntW'(1);
          if (!res.eq) begin
            gt        <= res.gt;
            eq        <= 1'b0;
            lt        <= res.lt;
            ncmp      <= cnt_q + CntW'(1);
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else if (idx_q == '0) begin
            gt        <= 1'b0;
            eq        <= 1'b1;
            lt        <= 1'b0;
            ncmp      <= CntW'(DIGITS);
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            sa_q  <= sa_q << DIGIT_W;
            sb_q  <= sb_q << DIGIT_W;
            idx_q <= idx_q - CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            ncmp      <= '0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed and random self-checking bench for serial_mag_comparator (WIDTH=8).
module tb_serial_mag_comparator;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             gt, eq, lt;
  logic [2:0]       ncmp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .ncmp      (ncmp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {gt,eq,lt} and number of digits up to the first differing one.
  function automatic void model(input logic [7:0] x, input logic [7:0] y,
                                output logic [2:0] f, output int n);
    n = 4;
    for (int d = 0; d < 4; d++) begin
      if (x[2*d +: 2] != y[2*d +: 2]) n = 4 - d;
    end
`ifdef SERIAL_CMP_SIGNED_EN
    f = {$signed(x) > $signed(y), x == y, $signed(x) < $signed(y)};
`else
    f = {x > y, x == y, x < y};
`endif
  endfunction

  // One full transaction: accept, measure latency, optional backpressure, transfer.
  task automatic run_pair(input logic [7:0] xa, input logic [7:0] xb, input logic [2:0] ef,
                          input int en, input int hold, input bit pre_ready);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_ready", in_ready, 1);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    out_ready = pre_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_in_ready", in_ready, 0);
    t = 0;
    while (out_valid !== 1'b1 && t < 12) begin
      @(posedge clk); #1;
      t++;
    end
    check("latency", t, en);
    check("flags", {gt, eq, lt}, ef);
    check("ncmp", ncmp, en);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = ~xa;
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_flags", {gt, eq, lt}, ef);
      check("bp_ncmp", ncmp, en);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_flags", {gt, eq, lt}, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [2:0] f;
    int n;
    logic [7:0] ra, rb;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {gt, eq, lt}, 0);
    check("rst_ncmp", ncmp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1);

    // Directed vectors: {gt,eq,lt} = 100 gt, 010 eq, 001 lt
    run_pair(8'hA5, 8'hA5, 3'b010, 4, 0, 1'b0);
`ifdef SERIAL_CMP_SIGNED_EN
    run_pair(8'h80, 8'h7F, 3'b001, 1, 0, 1'b0);
`else
    run_pair(8'h80, 8'h7F, 3'b100, 1, 0, 1'b0);
`endif
    run_pair(8'h12, 8'h13, 3'b001, 4, 0, 1'b0);
    run_pair(8'h3C, 8'h2C, 3'b100, 2, 0, 1'b1);
    run_pair(8'h01, 8'h00, 3'b100, 4, 5, 1'b0);

    // Reset after two digits of a four-digit compare
    a = 8'hFF;
    b = 8'hFE;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_flags", {gt, eq, lt}, 0);
    check("mid_rst_ncmp", ncmp, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_stale_valid", out_valid, 0);
    end
    run_pair(8'h00, 8'h00, 3'b010, 4, 0, 1'b0);

    // Random back-to-back stream
    for (int i = 0; i < 1000; i++) begin
      int hold;
      bit pre;
      ra = 8'($urandom_range(0, 255));
      rb = (i % 4 == 0) ? ra ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      if (i % 16 == 0) rb = ra;
      model(ra, rb, f, n);
      hold = $urandom_range(0, 2);
      pre = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_pair(ra, rb, f, n, hold, pre);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
